// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline types: stage payload structs, pipeline control bundle and
// the sizing limits used by the elastic stage buffers.
package pipe_stage_buffer_pkg;

  // Largest entry count a stage buffer may be built with.
  localparam int PIPE_BUF_MAX_DEPTH = 8;

  // Per-stage control: flush squashes in-flight work, stall holds it.
  typedef struct packed {
    logic flush;
    logic stall;
  } pipe_ctrl_t;

  // Decode -> Execute payload; 64 bits so it drops into the default WIDTH.
  typedef struct packed {
    logic [31:0] pc;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } execute_stage_pipe_reg_t;

  // Width of an index into a DEPTH-entry array; a single entry still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buffer_wrap_counter.sv
// Modulo-MAX pointer counter: counts 0..MAX-1 and wraps by explicit compare,
// so MAX need not be a power of two. clear wins over inc.
module wrap_counter
  import pipe_stage_buffer_pkg::*;
#(
  parameter  int MAX = 2,
  localparam int W   = ptr_width(MAX)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  // Pointer register: reset/clear to zero, otherwise advance and wrap at LAST.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      if (value == LAST) begin
        value <= '0;
      end else begin
        value <= value + W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline register between two core stages. Holds up to DEPTH
// payloads of WIDTH bits behind a valid/ready handshake. out_data always
// comes straight from storage, so there is never a combinational path from
// in_data to out_data. flush_i squashes everything buffered plus this
// cycle's input and hides the head from downstream in the same cycle.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter  int WIDTH      = 64,
  parameter  int DEPTH      = 2,
  parameter  int READY_PASS = 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam bit               PASS     = (READY_PASS != 0);

  if (DEPTH < 1 || DEPTH > PIPE_BUF_MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage_buffer: DEPTH=%0d outside 1..%0d", DEPTH, PIPE_BUF_MAX_DEPTH);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_stage_buffer: WIDTH=%0d must be at least 1", WIDTH);
  end

  pipe_ctrl_t       ctrl;
  logic             enq;
  logic             deq;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] mem [DEPTH];

  // Handshake decode: a full buffer only takes new data when READY_PASS lets
  // the consumer free the head slot in the same cycle.
  always_comb begin
    ctrl       = '0;
    ctrl.flush = flush_i;
    ctrl.stall = ~out_ready;
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    in_ready   = ~ctrl.flush & (~full | (PASS & ~ctrl.stall));
    out_valid  = ~empty & ~ctrl.flush;
    enq        = in_valid & in_ready;
    deq        = out_valid & out_ready;
  end

  assign out_data = mem[rd_ptr];
  assign count    = count_q;

  wrap_counter #(.MAX(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (enq),
    .clear (flush_i),
    .value (wr_ptr)
  );

  wrap_counter #(.MAX(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (deq),
    .clear (flush_i),
    .value (rd_ptr)
  );

  // Payload storage: written at the tail on enqueue; left untouched by flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enq) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Occupancy: simultaneous enqueue and dequeue leave it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rstn)
    count_q <= FULL_CNT);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    !(enq && full && !deq));

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer. Three instances:
//   dut 0: DEPTH=2 READY_PASS=1, dut 1: DEPTH=3 READY_PASS=1, dut 2: DEPTH=3 READY_PASS=0.
module tb_pipe_stage_buffer;

  localparam int WIDTH = 8;
  localparam int NDUT  = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush_i   [NDUT];
  logic             in_valid  [NDUT];
  logic             in_ready  [NDUT];
  logic [WIDTH-1:0] in_data   [NDUT];
  logic             out_valid [NDUT];
  logic             out_ready [NDUT];
  logic [WIDTH-1:0] out_data  [NDUT];
  logic [1:0]       count     [NDUT];

  logic [WIDTH-1:0] exp_q0 [$];
  logic [WIDTH-1:0] exp_q1 [$];
  logic [WIDTH-1:0] exp_q2 [$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.WIDTH(WIDTH), .DEPTH(2), .READY_PASS(1)) dut0 (
    .clk(clk), .rstn(rstn), .flush_i(flush_i[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .count(count[0])
  );

  pipe_stage_buffer #(.WIDTH(WIDTH), .DEPTH(3), .READY_PASS(1)) dut1 (
    .clk(clk), .rstn(rstn), .flush_i(flush_i[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .count(count[1])
  );

  pipe_stage_buffer #(.WIDTH(WIDTH), .DEPTH(3), .READY_PASS(0)) dut2 (
    .clk(clk), .rstn(rstn), .flush_i(flush_i[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .count(count[2])
  );

  // Scoreboard queue helpers, one queue per instance.
  function automatic void push_exp(input int d, input logic [WIDTH-1:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pop_exp(input int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every transfer the DUT presents must match the queue head.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rstn === 1'b1 && out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
        checks++;
        if (q_size(d) == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_out dut%0d actual=%0h expected=none", d, out_data[d]);
        end else begin
          logic [WIDTH-1:0] exp_v;
          exp_v = pop_exp(d);
          if (out_data[d] !== exp_v) begin
            failures++;
            $display("[TB] FAIL out_data dut%0d actual=%0h expected=%0h", d, out_data[d], exp_v);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic valid, input logic [WIDTH-1:0] data,
                               input logic rdy, input logic flush);
    in_valid[d]  = valid;
    in_data[d]   = data;
    out_ready[d] = rdy;
    flush_i[d]   = flush;
  endtask

  // Offer one word; it is expected at the output once the handshake completes.
  task automatic pushWord(input int d, input logic [WIDTH-1:0] data, input int max_wait);
    bit accepted = 0;
    int waited   = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    while (!accepted && waited < max_wait) begin
      @(negedge clk);
      accepted = (in_ready[d] === 1'b1);
      step();
      waited++;
    end
    in_valid[d] = 1'b0;
    if (accepted) begin
      push_exp(d, data);
    end else begin
      checks++;
      failures++;
      $display("[TB] FAIL push_timeout dut%0d actual=not_accepted expected=accepted", d);
    end
  endtask

  task automatic drain(input int d, input int max_cycles);
    int n = 0;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    while (q_size(d) != 0 && n < max_cycles) begin
      step();
      n++;
    end
    checkOutput($sformatf("drain_left_dut%0d", d), q_size(d), 0);
  endtask

  // Fill a 3-deep buffer while stalled, then offer 0xD while releasing the stall.
  task automatic fillAndPass(input int d, input bit pass);
    out_ready[d] = 1'b0;
    pushWord(d, 8'h0A, 4);
    pushWord(d, 8'h0B, 4);
    pushWord(d, 8'h0C, 4);
    checkOutput($sformatf("full_count_dut%0d", d), count[d], 3);
    @(negedge clk);
    checkOutput($sformatf("full_in_ready_dut%0d", d), in_ready[d], 0);
    step();
    applyStimulus(d, 1'b1, 8'h0D, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput($sformatf("pass_in_ready_dut%0d", d), in_ready[d], pass ? 1 : 0);
    step();
    if (pass) begin
      push_exp(d, 8'h0D);
      in_valid[d] = 1'b0;
      checkOutput($sformatf("pass_count_dut%0d", d), count[d], 3);
    end else begin
      checkOutput($sformatf("bubble_count_dut%0d", d), count[d], 2);
      pushWord(d, 8'h0D, 4);
    end
    drain(d, 12);
    checkOutput($sformatf("drained_count_dut%0d", d), count[d], 0);
  endtask

  // Hard stop if anything above ever hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < NDUT; d++) applyStimulus(d, 1'b1, 8'hEE, 1'b1, 1'b0);

    // Reset state while upstream is offering data
    #12;
    checkOutput("rst_out_valid", out_valid[0], 0);
    checkOutput("rst_count", count[0], 0);
    checkOutput("rst_in_ready", in_ready[0], 1);
    checkOutput("rst_out_data", out_data[0], 0);
    checkOutput("rst_in_ready_d1", in_ready[1], 1);
    for (int d = 0; d < NDUT; d++) in_valid[d] = 1'b0;
    #1 rstn = 1'b1;
    step();
    step();
    checkOutput("post_rst_count", count[0], 0);
    checkOutput("post_rst_out_valid", out_valid[0], 0);

    // Back-to-back stream through the 2-deep buffer
    for (int v = 1; v <= 10; v++) begin
      pushWord(0, WIDTH'(v), 4);
      checkOutput($sformatf("stream_latency_%0d", v), out_data[0], v);
      checkOutput($sformatf("stream_count_%0d", v), count[0], 1);
    end
    drain(0, 6);
    checkOutput("stream_end_count", count[0], 0);

    // Full buffer with and without the ready pass-through
    fillAndPass(1, 1'b1);
    fillAndPass(2, 1'b0);

    // Pointer wrap under alternating stalls
    out_ready[1] = 1'b1;
    fork
      begin
        for (int v = 0; v < 7; v++) pushWord(1, WIDTH'(8'h21 + v), 6);
      end
      begin
        repeat (20) begin
          out_ready[1] = ~out_ready[1];
          step();
        end
        out_ready[1] = 1'b1;
      end
    join
    drain(1, 12);

    // Flush with two entries buffered and a word on the input
    out_ready[0] = 1'b0;
    pushWord(0, 8'h31, 4);
    pushWord(0, 8'h32, 4);
    checkOutput("pre_flush_count", count[0], 2);
    exp_q0.delete();
    applyStimulus(0, 1'b1, 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush_out_valid", out_valid[0], 0);
    checkOutput("flush_in_ready", in_ready[0], 0);
    step();
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_flush_count", count[0], 0);
    checkOutput("post_flush_out_valid", out_valid[0], 0);
    pushWord(0, 8'h66, 4);
    checkOutput("after_flush_data", out_data[0], 8'h66);
    checkOutput("after_flush_valid", out_valid[0], 1);
    drain(0, 6);

    // Asynchronous reset between edges while stalled
    out_ready[0] = 1'b0;
    pushWord(0, 8'h41, 4);
    pushWord(0, 8'h42, 4);
    checkOutput("pre_areset_count", count[0], 2);
    #2;
    rstn = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    #1;
    checkOutput("areset_count", count[0], 0);
    checkOutput("areset_out_valid", out_valid[0], 0);
    checkOutput("areset_out_data", out_data[0], 0);
    checkOutput("areset_in_ready", in_ready[0], 1);
    step();
    #2 rstn = 1'b1;
    out_ready[0] = 1'b1;
    step();
    checkOutput("final_count", count[0], 0);
    checkOutput("final_queues", q_size(0) + q_size(1) + q_size(2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
